// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared router types: address/flit widths, flit type
//                encoding, flit layout and the receiver checker states.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int PAYLOAD_W = 22;
    localparam int FLIT_W    = 2 + 4 * ADDR_W + PAYLOAD_W;

    typedef enum logic [1:0] {
        HEAD   = 2'b00,
        BODY   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    typedef struct packed {
        flit_type_t            flit_type;
        logic [ADDR_W-1:0]     xdest;
        logic [ADDR_W-1:0]     ydest;
        logic [ADDR_W-1:0]     xsrc;
        logic [ADDR_W-1:0]     ysrc;
        logic [PAYLOAD_W-1:0]  payload;
    } FLIT_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rx_fifo
//  Description : Synchronous FIFO with a combinational head read and a
//                free-slot count. The caller gates push/pop: a push is only
//                issued when a slot is (or is simultaneously being) freed.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign dout     = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign free_cnt = CW'(DEPTH) - count;

endmodule
`default_nettype wire

// File: rtl/traffic_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_receiver
//  Description : Ejection endpoint for a router LOCAL port. Captures flits
//                under on/off flow control, buffers them, drains at the
//                consumer's pace, checks packet framing/destination/sequence
//                and keeps saturating packet, flit and error statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_receiver
    import router_pkg::*;
#(
    parameter int XADDR = 0,
    parameter int YADDR = 0,
    parameter int DEPTH = 4,
    parameter int SLACK = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [FLIT_W-1:0]     i_flit,
    input  logic                  i_rec_req,
    output logic                  o_rec_ack,
    input  logic                  i_drain_en,
    output logic [FLIT_W-1:0]     o_flit,
    output logic                  o_pop,
    output logic [CNT_W-1:0]      o_pkt_cnt,
    output logic [CNT_W-1:0]      o_flit_cnt,
    output logic [CNT_W-1:0]      o_err_cnt,
    output logic                  o_overflow,
    output logic [2*ADDR_W-1:0]   o_last_src
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              full;
    logic              empty;
    logic [CW-1:0]     free_cnt;
    logic [CW-1:0]     free_nxt;
    logic [FLIT_W-1:0] fifo_dout;
    FLIT_t             head;
    logic              pop_ok;
    logic              push_ok;
    logic              ovf_evt;
    logic [1:0]        err_inc;

    rx_state_t         state;
    rx_state_t         state_d;
    logic [7:0]        seq;
    logic [7:0]        seq_d;
    logic              start;
    logic              pkt_inc;
    logic              chk_err;
    logic              latch_src;
    logic              dest_bad;

    // A popping cycle frees a slot, so a full FIFO can still accept a flit.
    assign pop_ok   = i_drain_en && !empty;
    assign push_ok  = i_rec_req && (!full || pop_ok);
    assign ovf_evt  = i_rec_req && full && !pop_ok;
    assign free_nxt = free_cnt - CW'(push_ok) + CW'(pop_ok);

    rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset_n),
        .push     (push_ok),
        .pop      (pop_ok),
        .din      (i_flit),
        .dout     (fifo_dout),
        .full     (full),
        .empty    (empty),
        .free_cnt (free_cnt)
    );

    assign head     = FLIT_t'(fifo_dout);
    assign dest_bad = (head.xdest != ADDR_W'(XADDR)) || (head.ydest != ADDR_W'(YADDR));

    // Saturating add used by all statistics counters.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Checker state register: packet-in-progress flag and expected sequence.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
            seq   <= '0;
        end else begin
            state <= state_d;
            seq   <= seq_d;
        end
    end

    // Checker next-state: a HEAD/SINGLE inside a packet abandons it and is
    // then handled exactly as if it had arrived in IDLE.
    always_comb begin
        state_d   = state;
        seq_d     = seq;
        start     = 1'b0;
        pkt_inc   = 1'b0;
        chk_err   = 1'b0;
        latch_src = 1'b0;
        if (pop_ok) begin
            case (state)
                IDLE: start = 1'b1;
                IN_PKT: begin
                    case (head.flit_type)
                        BODY: begin
                            if (head.payload[7:0] != seq) chk_err = 1'b1;
                            seq_d = seq + 8'd1;
                        end
                        TAIL: begin
                            if (head.payload[7:0] != seq) chk_err = 1'b1;
                            pkt_inc = 1'b1;
                            state_d = IDLE;
                        end
                        default: begin
                            chk_err = 1'b1;
                            start   = 1'b1;
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
            if (start) begin
                case (head.flit_type)
                    HEAD: begin
                        if (dest_bad) chk_err = 1'b1;
                        latch_src = 1'b1;
                        seq_d     = 8'd0;
                        state_d   = IN_PKT;
                    end
                    SINGLE: begin
                        if (dest_bad) chk_err = 1'b1;
                        latch_src = 1'b1;
                        pkt_inc   = 1'b1;
                        state_d   = IDLE;
                    end
                    default: begin
                        chk_err = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // Overflow and checker are separate error sources; both may add at once.
    assign err_inc = {1'b0, ovf_evt} + {1'b0, chk_err};

    // Output registers: pop strobe/data, flow control and statistics.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            o_flit     <= '0;
            o_pop      <= 1'b0;
            o_rec_ack  <= 1'b1;
            o_pkt_cnt  <= '0;
            o_flit_cnt <= '0;
            o_err_cnt  <= '0;
            o_overflow <= 1'b0;
            o_last_src <= '0;
        end else begin
            o_pop      <= pop_ok;
            if (pop_ok) o_flit <= fifo_dout;
            o_rec_ack  <= (free_nxt > CW'(SLACK));
            o_pkt_cnt  <= sat_add(o_pkt_cnt, {1'b0, pkt_inc});
            o_flit_cnt <= sat_add(o_flit_cnt, {1'b0, push_ok});
            o_err_cnt  <= sat_add(o_err_cnt, err_inc);
            if (ovf_evt)   o_overflow <= 1'b1;
            if (latch_src) o_last_src <= {head.ysrc, head.xsrc};
        end
    end

endmodule
`default_nettype wire

// File: doc/traffic_receiver.md
Name: traffic_receiver

Overview:
Ejection-side endpoint for a router LOCAL output port: the receiving counterpart of the traffic generator's injection path. Accepts flits under on/off flow control, buffers them in a small FIFO, and drains them at a controllable rate. Checks packet framing and destination, and keeps packet, flit and error statistics for mesh-level benches.

Parameters:
XADDR, 0, column address of the attached router; head xdest must equal it
YADDR, 0, row address of the attached router; head ydest must equal it
DEPTH, 4, receive FIFO depth in flits (power of 2, >= SLACK+1)
SLACK, 2, free slots reserved to absorb in-flight flits after off is signalled
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-high reset (asserted = 1); name kept for codebase consistency
i_flit  in  FLIT_W  flit from router LOCAL output (router_pkg FLIT_t)
i_rec_req  in  1  flit valid; flit is captured in every cycle it is high (no refusal)
o_rec_ack  out  1  on/off flow control: 1 = upstream may send, 0 = stop
i_drain_en  in  1  consumer ready; pops one flit per cycle while FIFO is non-empty
o_flit  out  FLIT_W  flit popped this cycle (valid when o_pop = 1)
o_pop  out  1  one-cycle strobe per consumed flit
o_pkt_cnt  out  CNT_W  completed packets (TAIL or SINGLE checked)
o_flit_cnt  out  CNT_W  flits captured into the FIFO
o_err_cnt  out  CNT_W  framing, destination, sequence and overflow errors
o_overflow  out  1  sticky; a flit arrived while the FIFO was full
o_last_src  out  2*ADDR_W  {ysrc, xsrc} of the last accepted HEAD or SINGLE

Behaviour:
- Reset: all outputs 0 except o_rec_ack = 1. FIFO empty, FSM in IDLE, sequence register 0. Asserting reset mid-packet discards FIFO contents and partial-packet state immediately.
- Capture: when i_rec_req = 1 and the FIFO is not full, write the flit and increment o_flit_cnt.
  - If the FIFO is full: drop the flit, set o_overflow, increment o_err_cnt.
  - A simultaneous pop frees the slot in the same cycle, so full-and-popping counts as not full.
- On/off: o_rec_ack is registered. o_rec_ack = (free slots after this cycle's push/pop) > SLACK. It reasserts the cycle after occupancy drops back.
- Drain: if i_drain_en = 1 and the FIFO is non-empty, the head is popped. o_flit and o_pop are registered, so there is 1 cycle of latency from pop to the o_pop strobe. FIFO pointers wrap modulo DEPTH.
- Checker FSM runs on popped flits. States: IDLE, IN_PKT.
  - IDLE + HEAD: check the destination, latch the source into o_last_src, set seq = 0, go to IN_PKT.
  - IDLE + SINGLE: check the destination, latch the source, increment o_pkt_cnt, stay in IDLE.
  - IDLE + BODY or TAIL: framing error, stay in IDLE.
  - IN_PKT + BODY: payload[7:0] must equal seq, else sequence error; seq increments mod 256.
  - IN_PKT + TAIL: same seq check, increment o_pkt_cnt, go to IDLE.
  - IN_PKT + HEAD or SINGLE: framing error. The new flit restarts packet processing as if arriving in IDLE; the old packet is not counted.
  - Destination mismatch (xdest != XADDR or ydest != YADDR): error, but the packet is still tracked and counted.
- Error counting: at most one o_err_cnt increment per error source per cycle. An overflow and a checker error in the same cycle add 2.
- Counters saturate at all-ones.

Decomposition:
- router_pkg gains the flit type encoding flit_type_t (HEAD=2'b00, BODY=2'b01, TAIL=2'b10, SINGLE=2'b11).
- FLIT_t fields: flit_type, xdest, ydest, xsrc, ysrc, payload.
- ADDR_W and FLIT_W live in router_pkg and are reused.
- One sub-module: rx_fifo (synchronous FIFO with push, pop, full, empty and a free-slot count). The FSM, checker and counters stay in traffic_receiver.

Test Plan:
- Reset mid-packet: drive HEAD, BODY, then assert reset_n = 1 -> all counters 0, o_rec_ack = 1; a following TAIL raises o_err_cnt to 1 (framing).
- Single packet (XADDR=1, YADDR=0): HEAD(dest 1,0; src 0,0), BODY payload 0, BODY payload 1, TAIL payload 2, i_drain_en = 1 -> o_pkt_cnt = 1, o_flit_cnt = 4, o_err_cnt = 0, o_last_src = {0,0}; o_pop fires 4 times, each 1 cycle after its pop.
- Backpressure (DEPTH=4, SLACK=2, i_drain_en = 0): one flit per cycle -> o_rec_ack falls after the 2nd capture. 4 flits fit with no overflow; a 5th sets o_overflow = 1 and o_err_cnt = 1. Raising i_drain_en reasserts o_rec_ack once free slots exceed 2.
- Framing: BODY while IDLE -> o_err_cnt += 1. HEAD, then HEAD -> o_err_cnt += 1; the second HEAD opens a packet that completes on TAIL with o_pkt_cnt += 1.
- Misroute and sequence: SINGLE with xdest = 3 -> o_err_cnt = 1, o_pkt_cnt = 1. HEAD, BODY payload 5 (expected 0) -> o_err_cnt = 2.
- Simultaneous push/pop at full: hold 4 flits, then push and pop in the same cycle -> flit accepted, o_overflow stays 0, occupancy stays 4.
